// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-channel valid/ready stream mux with internal arbiter and registered output
//
// Purpose: selects one of N requesters per beat (round-robin or fixed priority),
// holds the selection for the whole packet (until in_last), and registers the
// chosen beat toward a single shared consumer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [N]        per-channel beat valid
//   in_ready   [N]        per-channel beat accepted (combinational, one-hot or zero)
//   in_data    [N*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   in_last    [N]        per-channel end-of-packet flag
//   out_valid             registered output beat valid
//   out_ready             consumer accepts the output beat
//   out_data   [WIDTH]    registered data
//   out_last              registered last flag
//   out_sel    [SELW]     channel that sourced the current output beat

module stream_mux_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_sel
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   lock_ch_q, lock_ch_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SELW-1:0]   out_sel_q, out_sel_d;

  logic [SELW-1:0]   g;
  logic              grant_exists;
  logic              load_en;
  logic              accept;
  logic [SELW-1:0]   idx_sel;
  int                idx;

  // The output register can take a new beat when empty or draining this cycle.
  assign load_en = !out_valid_q | out_ready;

  // Grant search. Loops run from the lowest-priority candidate down to the
  // highest so the last hit written is the winner, avoiding a found flag.
  always_comb begin
    g            = '0;
    grant_exists = 1'b0;
    idx          = 0;
    idx_sel      = '0;
    if (state_q == LOCK) begin
      g            = lock_ch_q;
      grant_exists = 1'b1;
    end else if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        idx_sel = SELW'(i);
        if (in_valid[idx_sel]) begin
          g            = idx_sel;
          grant_exists = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        idx_sel = SELW'(idx);
        if (in_valid[idx_sel]) begin
          g            = idx_sel;
          grant_exists = 1'b1;
        end
      end
    end
  end

  // Ready goes to the granted channel only; held low throughout reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && grant_exists && load_en) in_ready[g] = 1'b1;
  end

  assign accept = |(in_valid & in_ready);

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(g)*WIDTH +: WIDTH];
      out_last_d  = in_last[g];
      out_sel_d   = g;
      if (in_last[g]) begin
        state_d = IDLE;
        // Pointer moves only at packet boundaries; explicit wrap handles non-power-of-two N.
        if (MODE == 0) ptr_d = (int'(g) == N - 1) ? '0 : SELW'(int'(g) + 1);
      end else begin
        state_d   = LOCK;
        lock_ch_d = g;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule
